cpu: RTL and testbench
======================

CPU -- requirements
Module: cpu

Interface
REQ-001 Parameter IMEM_WORDS, default 256, instruction memory depth in 32-bit words.
REQ-002 Parameter DMEM_WORDS, default 256, data memory depth in 32-bit words.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 No other ports; state is reached through hierarchy: instance imem (array memory[0:IMEM_WORDS-1] of 32 bits), dmem (array memory[0:DMEM_WORDS-1] of 32 bits), rf (array registers[0:31] of 32 bits).
REQ-006 imem.memory and dmem.memory SHALL be plain unpacked word arrays loadable by $readmemh before reset deasserts; memory[i] holds byte address 4*i.

Function
REQ-007 Single-cycle RV32I subset: fetch, decode, execute, memory access and writeback of one instruction per clk cycle.
REQ-008 Supported: LUI, AUIPC, JAL, JALR, BEQ, BNE, LW, SW, ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
REQ-009 Any other opcode/funct combination SHALL execute as a NOP (no register/memory write, PC+4).
REQ-010 Instruction fetch and data read are combinational; imem index = PC[log2(IMEM_WORDS)+1:2], dmem index = addr[log2(DMEM_WORDS)+1:2]; upper bits ignored (address wraps), low two bits ignored (no misalignment trap).
REQ-011 Register write and SW memory write take effect at the rising edge ending the instruction's cycle; a result is readable by the next instruction.
REQ-012 rf.registers[0] SHALL read 0 and SHALL never be written to a non-zero value.
REQ-013 Arithmetic is 32-bit modulo 2^32; shift amounts use the low 5 bits; SLT/SLTI signed, SLTU/SLTIU unsigned; SRA/SRAI sign-fill.
REQ-014 Next PC: PC+4 default; branch taken -> PC+B-imm; JAL -> PC+J-imm; JALR -> (rs1+I-imm) with bit 0 cleared; JAL/JALR write PC+4 to rd.
REQ-015 PC SHALL wrap modulo 2^32; no trap on fetch outside imem (wraps per REQ-010).
REQ-016 rs1 == rd or rs2 == rd in the same instruction SHALL use the pre-edge register values.

Reset
REQ-017 When reset is high at a rising edge: PC <= 0, rf.registers[0..31] <= 0, no dmem write occurs.
REQ-018 imem and dmem contents SHALL NOT be altered by reset.
REQ-019 The first instruction (imem.memory[0]) executes in the first cycle after reset deasserts; reset asserted mid-program aborts the in-flight instruction's writes.

Configuration
REQ-020 Macro CPU_BRANCH_EXT_EN defined: BLT, BGE (signed) and BLTU, BGEU (unsigned) SHALL be supported.
REQ-021 Macro CPU_BRANCH_EXT_EN undefined: those four encodings SHALL behave as NOP per REQ-009.

Structure
REQ-022 Shared package cpu_pkg holds opcode constants, ALU operation enum and immediate-type enum.
REQ-023 Sub-modules: instruction memory (instance imem), data memory (instance dmem), register file (instance rf, 2 async read ports, 1 sync write port); the ALU is the one further natural sub-module (cpu_alu).

Verification
REQ-024 Program addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; reset 2 cycles -> after 3 cycles x1=5, x2=7, x3=12.
REQ-025 sw x3,8(x0) then lw x4,8(x0) with x3=12 -> dmem.memory[2]=12, x4=12; dmem data preloaded at other indices unchanged.
REQ-026 addi x1,x0,1; beq x0,x0,+8; addi x1,x0,99; addi x2,x0,3 -> x1=1, x2=3; bne x0,x0 not taken -> fall-through executed.
REQ-027 addi x0,x0,7 then add x5,x0,x0 -> x0=0, x5=0; jal x6,+8 at PC 0x10 -> x6=0x14.
REQ-028 Assert reset mid-program after x1=5 written -> PC=0, all registers 0, dmem unchanged; program reruns to same final state.
REQ-029 addi x1,x0,-1; blt x1,x0,+8; addi x2,x0,9 -> with CPU_BRANCH_EXT_EN x2=0, without x2=9.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, ALU/immediate enums and decode helpers for cpu
package cpu_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_t;

    // Only instruction bits above the opcode carry immediate fields.
    function automatic logic [31:0] gen_imm(input logic [31:7] ins, input imm_type_t kind);
        logic [31:0] imm;
        case (kind)
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm = {ins[31:12], 12'd0};
            IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = {{20{ins[31]}}, ins[31:20]};
        endcase
        return imm;
    endfunction

    function automatic alu_op_t funct3_to_alu_op(input logic [2:0] funct3, input logic alt);
        alu_op_t op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational RV32I integer ALU
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     op,
    output logic [31:0] y
);

    always_comb begin
        y = 32'd0;
        case (op)
            ALU_ADD:    y = a + b;
            ALU_SUB:    y = a - b;
            ALU_SLL:    y = a << b[4:0];
            ALU_SLT:    y = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU:   y = {31'd0, a < b};
            ALU_XOR:    y = a ^ b;
            ALU_SRL:    y = a >> b[4:0];
            ALU_SRA:    y = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:     y = a | b;
            ALU_AND:    y = a & b;
            ALU_PASS_B: y = b;
            default:    y = 32'd0;
        endcase
    end

endmodule

// File: rtl/cpu_mem.sv
// rtl/cpu_mem.sv - word-addressed memory, combinational read, synchronous write
module cpu_mem #(
    parameter int WORDS = 256,
    localparam int AW = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] memory [0:WORDS-1];

    // No reset: contents survive cpu reset and may be preloaded by the bench.
    always_ff @(posedge clk) begin
        if (we) begin
            memory[addr] <= wdata;
        end
    end

    assign rdata = memory[addr];

endmodule

// File: rtl/cpu_regfile.sv
// rtl/cpu_regfile.sv - 32x32 register file, two async read ports, one sync write port
module cpu_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] registers [0:31];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                registers[i] <= 32'd0;
            end
        end else if (we && waddr != 5'd0) begin
            registers[waddr] <= wdata;
        end
    end

    assign rdata1 = registers[raddr1];
    assign rdata2 = registers[raddr2];

endmodule

// File: rtl/cpu.sv
// rtl/cpu.sv - single-cycle RV32I subset core; CPU_BRANCH_EXT_EN adds BLT/BGE/BLTU/BGEU
module cpu
    import cpu_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input logic clk,
    input logic reset
);

    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic [31:0] mem_rdata;
    logic [31:0] wb_data;

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    alu_op_t     alu_op;
    imm_type_t   imm_type;
    logic        reg_we;
    logic        mem_we;
    logic        is_load;
    logic        is_jal;
    logic        is_jalr;
    logic        is_branch;
    logic        use_pc_a;
    logic        use_imm_b;
    logic        branch_taken;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    // Unrecognised encodings leave every write enable low, so they retire as NOPs.
    always_comb begin
        reg_we    = 1'b0;
        mem_we    = 1'b0;
        is_load   = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_branch = 1'b0;
        use_pc_a  = 1'b0;
        use_imm_b = 1'b1;
        imm_type  = IMM_I;
        alu_op    = ALU_ADD;
        case (opcode)
            OP_LUI: begin
                reg_we   = 1'b1;
                imm_type = IMM_U;
                alu_op   = ALU_PASS_B;
            end
            OP_AUIPC: begin
                reg_we   = 1'b1;
                imm_type = IMM_U;
                use_pc_a = 1'b1;
            end
            OP_JAL: begin
                reg_we   = 1'b1;
                is_jal   = 1'b1;
                imm_type = IMM_J;
            end
            OP_JALR: begin
                reg_we  = funct3 == 3'b000;
                is_jalr = funct3 == 3'b000;
            end
            OP_BRANCH: begin
                is_branch = 1'b1;
                imm_type  = IMM_B;
            end
            OP_LOAD: begin
                reg_we  = funct3 == 3'b010;
                is_load = funct3 == 3'b010;
            end
            OP_STORE: begin
                mem_we   = funct3 == 3'b010;
                imm_type = IMM_S;
            end
            OP_IMM: begin
                alu_op = funct3_to_alu_op(funct3, funct3 == 3'b101 && funct7[5]);
                case (funct3)
                    3'b001:  reg_we = funct7 == 7'b0000000;
                    3'b101:  reg_we = funct7 == 7'b0000000 || funct7 == 7'b0100000;
                    default: reg_we = 1'b1;
                endcase
            end
            OP_REG: begin
                use_imm_b = 1'b0;
                alu_op    = funct3_to_alu_op(funct3, funct7[5]);
                reg_we    = funct7 == 7'b0000000 ||
                            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            default: ;
        endcase
    end

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = rs1_data == rs2_data;
            3'b001:  branch_taken = rs1_data != rs2_data;
`ifdef CPU_BRANCH_EXT_EN
            3'b100:  branch_taken = $signed(rs1_data) <  $signed(rs2_data);
            3'b101:  branch_taken = $signed(rs1_data) >= $signed(rs2_data);
            3'b110:  branch_taken = rs1_data <  rs2_data;
            3'b111:  branch_taken = rs1_data >= rs2_data;
`else
            3'b100, 3'b101, 3'b110, 3'b111: branch_taken = 1'b0;
`endif
            default: branch_taken = 1'b0;
        endcase
    end

    assign imm      = gen_imm(instr[31:7], imm_type);
    assign alu_a    = use_pc_a ? pc : rs1_data;
    assign alu_b    = use_imm_b ? imm : rs2_data;
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        pc_next = pc_plus4;
        if (is_jal || (is_branch && branch_taken)) begin
            pc_next = pc + imm;
        end else if (is_jalr) begin
            pc_next = {alu_y[31:1], 1'b0};
        end
    end

    always_comb begin
        wb_data = alu_y;
        if (is_jal || is_jalr) begin
            wb_data = pc_plus4;
        end else if (is_load) begin
            wb_data = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= 32'd0;
        end else begin
            pc <= pc_next;
        end
    end

    cpu_mem #(.WORDS(IMEM_WORDS)) imem (
        .clk   (clk),
        .we    (1'b0),
        .addr  (pc[IAW+1:2]),
        .wdata (32'd0),
        .rdata (instr)
    );

    // Store address comes from the ALU; reset suppresses the in-flight store.
    cpu_mem #(.WORDS(DMEM_WORDS)) dmem (
        .clk   (clk),
        .we    (mem_we && !reset),
        .addr  (alu_y[DAW+1:2]),
        .wdata (rs2_data),
        .rdata (mem_rdata)
    );

    cpu_regfile rf (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data),
        .we     (reg_we),
        .waddr  (rd),
        .wdata  (wb_data)
    );

    cpu_alu alu (
        .a  (alu_a),
        .b  (alu_b),
        .op (alu_op),
        .y  (alu_y)
    );

endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - self-checking bench for cpu: instruction vector table plus program sequences
module tb_cpu;

    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] OPIMM = 7'b0010011;
    localparam logic [6:0] OPREG = 7'b0110011;

    localparam int K_REG = 0;
    localparam int K_MEM = 1;
    localparam int K_PC  = 2;
    localparam int K_IMEM = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    cpu #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
        .clk   (clk),
        .reset (reset)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [31:0] value;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), OPREG};
    endfunction

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
        logic [31:0] v;
        v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(int imm20, int rd, logic [6:0] op);
        return {20'(imm20), 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
    endfunction

    // lui+addi pair; the +0x800 compensates for addi sign-extending its low 12 bits.
    task automatic load_li(int at, int rd, logic [31:0] value);
        logic [31:0] up;
        up = (value + 32'h800) >> 12;
        dut.imem.memory[at]     = enc_u(int'(up), rd, LUI);
        dut.imem.memory[at + 1] = enc_i(int'(value), rd, 0, rd, OPIMM);
    endtask

    task automatic begin_test();
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) begin
            dut.imem.memory[i] = 32'd0;
            dut.dmem.memory[i] = 32'd0;
        end
    endtask

    task automatic run(int reset_cycles, int cycles);
        reset = 1'b1;
        repeat (reset_cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_val(string name, int kind, int idx, logic [31:0] value);
        sb.push_back('{name, kind, idx, value});
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_REG:   act = dut.rf.registers[e.idx];
                K_MEM:   act = dut.dmem.memory[e.idx];
                K_IMEM:  act = dut.imem.memory[e.idx];
                default: act = dut.pc;
            endcase
            checks++;
            if (act !== e.value) begin
                errors++;
                $display("FAIL %s: got %08h expected %08h", e.name, act, e.value);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs.push_back('{"add",      enc_r(0, 2, 1, 0, 3),        32'd5,          32'd7,          32'd12});
        vecs.push_back('{"add_wrap", enc_r(0, 2, 1, 0, 3),        32'h7FFFFFFF,   32'd1,          32'h80000000});
        vecs.push_back('{"sub",      enc_r(32, 2, 1, 0, 3),       32'd5,          32'd7,          32'hFFFFFFFE});
        vecs.push_back('{"sll",      enc_r(0, 2, 1, 1, 3),        32'd1,          32'd33,         32'd2});
        vecs.push_back('{"slt",      enc_r(0, 2, 1, 2, 3),        32'hFFFFFFFF,   32'd1,          32'd1});
        vecs.push_back('{"sltu",     enc_r(0, 2, 1, 3, 3),        32'hFFFFFFFF,   32'd1,          32'd0});
        vecs.push_back('{"xor",      enc_r(0, 2, 1, 4, 3),        32'hF0F0F0F0,   32'h0FF00FF0,   32'hFF00FF00});
        vecs.push_back('{"srl",      enc_r(0, 2, 1, 5, 3),        32'h80000000,   32'd4,          32'h08000000});
        vecs.push_back('{"sra",      enc_r(32, 2, 1, 5, 3),       32'h80000000,   32'd4,          32'hF8000000});
        vecs.push_back('{"or",       enc_r(0, 2, 1, 6, 3),        32'h12340000,   32'h00005678,   32'h12345678});
        vecs.push_back('{"and",      enc_r(0, 2, 1, 7, 3),        32'hFFFF0000,   32'h0F0F0F0F,   32'h0F0F0000});
        vecs.push_back('{"mul_nop",  enc_r(1, 2, 1, 0, 3),        32'd5,          32'd7,          32'd0});
        vecs.push_back('{"addi_neg", enc_i(-1, 1, 0, 3, OPIMM),   32'd0,          32'd0,          32'hFFFFFFFF});
        vecs.push_back('{"slti",     enc_i(-3, 1, 2, 3, OPIMM),   32'hFFFFFFFB,   32'd0,          32'd1});
        vecs.push_back('{"sltiu",    enc_i(-1, 1, 3, 3, OPIMM),   32'd5,          32'd0,          32'd1});
        vecs.push_back('{"xori",     enc_i(240, 1, 4, 3, OPIMM),  32'h000000FF,   32'd0,          32'h0000000F});
        vecs.push_back('{"ori",      enc_i(240, 1, 6, 3, OPIMM),  32'h00000F00,   32'd0,          32'h00000FF0});
        vecs.push_back('{"andi",     enc_i(240, 1, 7, 3, OPIMM),  32'h00001234,   32'd0,          32'h00000030});
        vecs.push_back('{"slli",     enc_i(4, 1, 1, 3, OPIMM),    32'd3,          32'd0,          32'd48});
        vecs.push_back('{"slli_bad", enc_i(1028, 1, 1, 3, OPIMM), 32'd3,          32'd0,          32'd0});
        vecs.push_back('{"srli",     enc_i(28, 1, 5, 3, OPIMM),   32'hF0000000,   32'd0,          32'h0000000F});
        vecs.push_back('{"srai",     enc_i(1052, 1, 5, 3, OPIMM), 32'hF0000000,   32'd0,          32'hFFFFFFFF});
        vecs.push_back('{"lui",      enc_u(703710, 3, LUI),       32'd0,          32'd0,          32'hABCDE000});
        vecs.push_back('{"auipc",    enc_u(1, 3, AUIPC),          32'd0,          32'd0,          32'h00001010});

        // Three-instruction program, reset state, then rs==rd reads the pre-edge value.
        begin_test();
        dut.imem.memory[0] = enc_i(5, 0, 0, 1, OPIMM);
        dut.imem.memory[1] = enc_i(7, 0, 0, 2, OPIMM);
        dut.imem.memory[2] = enc_r(0, 2, 1, 0, 3);
        dut.imem.memory[3] = enc_r(0, 2, 2, 0, 2);
        reset = 1'b1;
        step(2);
        expect_val("reset_pc", K_PC, 0, 32'd0);
        for (int r = 0; r < 32; r++) begin
            expect_val($sformatf("reset_x%0d", r), K_REG, r, 32'd0);
        end
        drain();
        reset = 1'b0;
        step(3);
        expect_val("prog_x1", K_REG, 1, 32'd5);
        expect_val("prog_x2", K_REG, 2, 32'd7);
        expect_val("prog_x3", K_REG, 3, 32'd12);
        drain();
        step(1);
        expect_val("rs_eq_rd_x2", K_REG, 2, 32'd14);
        drain();

        foreach (vecs[k]) begin
            begin_test();
            load_li(0, 1, vecs[k].a);
            load_li(2, 2, vecs[k].b);
            dut.imem.memory[4] = vecs[k].instr;
            expect_val(vecs[k].name, K_REG, 3, vecs[k].expected);
            run(1, 5);
            drain();
        end

        // Store/load round trip, including an address that wraps past dmem.
        begin_test();
        dut.dmem.memory[1] = 32'hDEADBEEF;
        dut.dmem.memory[3] = 32'h000055AA;
        dut.imem.memory[0] = enc_i(12, 0, 0, 3, OPIMM);
        dut.imem.memory[1] = enc_s(8, 3, 0);
        dut.imem.memory[2] = enc_i(8, 0, 2, 4, LOAD);
        dut.imem.memory[3] = enc_i(1032, 0, 2, 5, LOAD);
        run(1, 4);
        expect_val("sw_mem2", K_MEM, 2, 32'd12);
        expect_val("lw_x4", K_REG, 4, 32'd12);
        expect_val("lw_wrap_x5", K_REG, 5, 32'd12);
        expect_val("mem1_kept", K_MEM, 1, 32'hDEADBEEF);
        expect_val("mem3_kept", K_MEM, 3, 32'h000055AA);
        drain();

        // beq taken skips one instruction, bne not taken falls through.
        begin_test();
        dut.imem.memory[0] = enc_i(1, 0, 0, 1, OPIMM);
        dut.imem.memory[1] = enc_b(8, 0, 0, 0);
        dut.imem.memory[2] = enc_i(99, 0, 0, 1, OPIMM);
        dut.imem.memory[3] = enc_i(3, 0, 0, 2, OPIMM);
        dut.imem.memory[4] = enc_b(8, 0, 0, 1);
        dut.imem.memory[5] = enc_i(4, 0, 0, 5, OPIMM);
        run(1, 5);
        expect_val("beq_x1", K_REG, 1, 32'd1);
        expect_val("beq_x2", K_REG, 2, 32'd3);
        expect_val("bne_x5", K_REG, 5, 32'd4);
        drain();

        // x0 stays zero; jal links PC+4; jalr clears bit 0 of its target.
        begin_test();
        dut.imem.memory[0] = enc_i(7, 0, 0, 0, OPIMM);
        dut.imem.memory[1] = enc_r(0, 0, 0, 0, 5);
        dut.imem.memory[4] = enc_j(8, 6);
        dut.imem.memory[5] = enc_i(1, 0, 0, 7, OPIMM);
        dut.imem.memory[6] = enc_i(2, 0, 0, 8, OPIMM);
        dut.imem.memory[7] = enc_i(17, 6, 0, 9, JALR);
        dut.imem.memory[8] = enc_i(1, 0, 0, 10, OPIMM);
        dut.imem.memory[9] = enc_i(2, 0, 0, 11, OPIMM);
        run(1, 8);
        expect_val("x0_zero", K_REG, 0, 32'd0);
        expect_val("x5_zero", K_REG, 5, 32'd0);
        expect_val("jal_x6", K_REG, 6, 32'h00000014);
        expect_val("jal_skip_x7", K_REG, 7, 32'd0);
        expect_val("jal_target_x8", K_REG, 8, 32'd2);
        expect_val("jalr_x9", K_REG, 9, 32'h00000020);
        expect_val("jalr_skip_x10", K_REG, 10, 32'd0);
        expect_val("jalr_target_x11", K_REG, 11, 32'd2);
        expect_val("jalr_pc", K_PC, 0, 32'h00000028);
        drain();

        // Reset with a store in flight, then rerun to the same final state.
        begin_test();
        dut.dmem.memory[0] = 32'h0000CAFE;
        dut.dmem.memory[1] = 32'h00001111;
        dut.imem.memory[0] = enc_i(5, 0, 0, 1, OPIMM);
        dut.imem.memory[1] = enc_i(1, 1, 0, 2, OPIMM);
        dut.imem.memory[2] = enc_s(4, 2, 0);
        dut.imem.memory[3] = enc_i(9, 0, 0, 3, OPIMM);
        run(1, 2);
        expect_val("pre_reset_x1", K_REG, 1, 32'd5);
        drain();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        expect_val("midreset_pc", K_PC, 0, 32'd0);
        expect_val("midreset_x1", K_REG, 1, 32'd0);
        expect_val("midreset_x2", K_REG, 2, 32'd0);
        expect_val("midreset_mem1", K_MEM, 1, 32'h00001111);
        expect_val("midreset_mem0", K_MEM, 0, 32'h0000CAFE);
        expect_val("midreset_imem0", K_IMEM, 0, enc_i(5, 0, 0, 1, OPIMM));
        drain();
        step(4);
        expect_val("rerun_x1", K_REG, 1, 32'd5);
        expect_val("rerun_x2", K_REG, 2, 32'd6);
        expect_val("rerun_x3", K_REG, 3, 32'd9);
        expect_val("rerun_mem1", K_MEM, 1, 32'd6);
        drain();

        // blt is only honoured when the extended branches are built in.
        begin_test();
        dut.imem.memory[0] = enc_i(-1, 0, 0, 1, OPIMM);
        dut.imem.memory[1] = enc_b(8, 0, 1, 4);
        dut.imem.memory[2] = enc_i(9, 0, 0, 2, OPIMM);
        dut.imem.memory[3] = enc_i(1, 0, 0, 3, OPIMM);
        run(1, 3);
`ifdef CPU_BRANCH_EXT_EN
        expect_val("blt_x2", K_REG, 2, 32'd0);
        expect_val("blt_x3", K_REG, 3, 32'd1);
`else
        expect_val("blt_x2", K_REG, 2, 32'd9);
        expect_val("blt_x3", K_REG, 3, 32'd0);
`endif
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
